// File: rtl/ecc_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ecc_arbiter_if
// Description : TX/RX requester and ecc datapath bundle seen by ecc_arbiter.
// Revision    : 1.0  initial release
// ============================================================================

`ifndef PACKET_SIZE
`define PACKET_SIZE 11
`endif
`ifndef FRAME_SIZE
`define FRAME_SIZE 15
`endif
`ifndef OP_ENCODE
`define OP_ENCODE 1'b0
`endif
`ifndef OP_DECODE
`define OP_DECODE 1'b1
`endif

interface ecc_arbiter_if #(
    parameter int PACKET_SIZE = `PACKET_SIZE,
    parameter int FRAME_SIZE  = `FRAME_SIZE
);
    logic                   tx_req;
    logic [PACKET_SIZE-1:0] tx_packet;
    logic                   tx_ack;
    logic [FRAME_SIZE-1:0]  tx_frame;

    logic                   rx_req;
    logic [FRAME_SIZE-1:0]  rx_frame;
    logic                   rx_ack;
    logic [PACKET_SIZE-1:0] rx_data;
    logic                   rx_ok;

    logic [PACKET_SIZE-1:0] ecc_packet;
    logic [FRAME_SIZE-1:0]  ecc_frame;
    logic                   ecc_operation;
    logic [FRAME_SIZE-1:0]  ecc_codeword;
    logic [PACKET_SIZE-1:0] ecc_data;
    logic                   ecc_irq;
    logic                   ecc_correct;

    logic                   timeout;
    logic [7:0]             err_count;

    // Environment side: requesters plus the ecc datapath.
    modport master (
        output tx_req, tx_packet, rx_req, rx_frame,
        output ecc_codeword, ecc_data, ecc_irq, ecc_correct,
        input  tx_ack, tx_frame, rx_ack, rx_data, rx_ok,
        input  ecc_packet, ecc_frame, ecc_operation, timeout, err_count
    );

    // Arbiter side.
    modport slave (
        input  tx_req, tx_packet, rx_req, rx_frame,
        input  ecc_codeword, ecc_data, ecc_irq, ecc_correct,
        output tx_ack, tx_frame, rx_ack, rx_data, rx_ok,
        output ecc_packet, ecc_frame, ecc_operation, timeout, err_count
    );
endinterface

`default_nettype wire

// File: rtl/ecc_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ecc_arbiter
// Description : Round-robin sequencer sharing one ecc engine between a TX
//               encode requester and an RX decode requester, with watchdog.
//               Optional: define ECC_ARB_ERR_COUNT_EN to build err_count.
// Revision    : 1.0  initial release
// ============================================================================

`ifndef PACKET_SIZE
`define PACKET_SIZE 11
`endif
`ifndef FRAME_SIZE
`define FRAME_SIZE 15
`endif
`ifndef OP_ENCODE
`define OP_ENCODE 1'b0
`endif
`ifndef OP_DECODE
`define OP_DECODE 1'b1
`endif

module ecc_arbiter #(
    parameter int PACKET_SIZE = `PACKET_SIZE,
    parameter int FRAME_SIZE  = `FRAME_SIZE,
    parameter int TIMEOUT     = 16
) (
    input  wire logic   clk,
    input  wire logic   reset,
    ecc_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] c_tmo_last = 8'(TIMEOUT - 1);

    state_t                 r_state;
    logic                   r_last_rx;
    logic                   r_grant_rx;
    logic [7:0]             r_cnt;
    logic                   r_tx_ack;
    logic                   r_rx_ack;
    logic                   r_timeout;
    logic                   r_rx_ok;
    logic [FRAME_SIZE-1:0]  r_tx_frame;
    logic [PACKET_SIZE-1:0] r_rx_data;
    logic [PACKET_SIZE-1:0] r_ecc_packet;
    logic [FRAME_SIZE-1:0]  r_ecc_frame;
    logic                   r_ecc_op;

    // TX wins when RX is idle or when RX was the side served last.
    logic w_pick_tx;
    assign w_pick_tx = bus.tx_req && (!bus.rx_req || r_last_rx);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_rx    <= 1'b1;
            r_grant_rx   <= 1'b0;
            r_cnt        <= 8'd0;
            r_tx_ack     <= 1'b0;
            r_rx_ack     <= 1'b0;
            r_timeout    <= 1'b0;
            r_rx_ok      <= 1'b0;
            r_tx_frame   <= '0;
            r_rx_data    <= '0;
            r_ecc_packet <= '0;
            r_ecc_frame  <= '0;
            r_ecc_op     <= `OP_ENCODE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pick_tx) begin
                        r_grant_rx   <= 1'b0;
                        r_ecc_packet <= bus.tx_packet;
                        r_ecc_op     <= `OP_ENCODE;
                        r_state      <= S_ISSUE;
                    end else if (bus.rx_req) begin
                        r_grant_rx  <= 1'b1;
                        r_ecc_frame <= bus.rx_frame;
                        r_ecc_op    <= `OP_DECODE;
                        r_state     <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    r_cnt   <= 8'd0;
                    r_state <= S_WAIT;
                end

                S_WAIT: begin
                    if (bus.ecc_irq) begin
                        if (r_grant_rx) begin
                            r_rx_data <= bus.ecc_data;
                            r_rx_ok   <= bus.ecc_correct;
                            r_rx_ack  <= 1'b1;
                        end else begin
                            r_tx_frame <= bus.ecc_codeword;
                            r_tx_ack   <= 1'b1;
                        end
                        r_state <= S_DONE;
                    end else if (r_cnt == c_tmo_last) begin
                        // Abort: data registers keep their previous contents.
                        r_timeout <= 1'b1;
                        if (r_grant_rx) begin
                            r_rx_ok  <= 1'b0;
                            r_rx_ack <= 1'b1;
                        end else begin
                            r_tx_ack <= 1'b1;
                        end
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                S_DONE: begin
                    r_tx_ack  <= 1'b0;
                    r_rx_ack  <= 1'b0;
                    r_timeout <= 1'b0;
                    r_last_rx <= r_grant_rx;
                    r_state   <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef ECC_ARB_ERR_COUNT_EN
    logic [7:0] r_err_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_count <= 8'd0;
        end else if (r_state == S_DONE && r_grant_rx && !r_rx_ok
                     && r_err_count != 8'hFF) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign bus.err_count = r_err_count;
`else
    assign bus.err_count = 8'd0;
`endif

    assign bus.tx_ack        = r_tx_ack;
    assign bus.tx_frame      = r_tx_frame;
    assign bus.rx_ack        = r_rx_ack;
    assign bus.rx_data       = r_rx_data;
    assign bus.rx_ok         = r_rx_ok;
    assign bus.ecc_packet    = r_ecc_packet;
    assign bus.ecc_frame     = r_ecc_frame;
    assign bus.ecc_operation = r_ecc_op;
    assign bus.timeout       = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_ecc_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ecc_arbiter
// Description : Scoreboard bench for ecc_arbiter with a Hamming(15,11) ecc model.
// Revision    : 1.0  initial release
// ============================================================================

module tb_ecc_arbiter;

    localparam int PS  = 11;
    localparam int FS  = 15;
    localparam int TMO = 16;

`ifdef ECC_ARB_ERR_COUNT_EN
    localparam int ERR_AFTER_TMO = 1;
    localparam int ERR_SAT       = 255;
`else
    localparam int ERR_AFTER_TMO = 0;
    localparam int ERR_SAT       = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ecc_arbiter_if #(.PACKET_SIZE(PS), .FRAME_SIZE(FS)) bus ();

    ecc_arbiter #(.PACKET_SIZE(PS), .FRAME_SIZE(FS), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Hamming(15,11): parity at positions 1,2,4,8 (1-based).
    function automatic logic [14:0] ham_enc(input logic [10:0] d);
        logic [14:0] c;
        logic        x;
        int          j;
        c = '0;
        j = 0;
        for (int p = 1; p <= 15; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p-1] = d[j];
                j++;
            end
        end
        for (int b = 1; b <= 8; b = b * 2) begin
            x = 1'b0;
            for (int p = 1; p <= 15; p++)
                if ((p & b) != 0 && p != b) x = x ^ c[p-1];
            c[b-1] = x;
        end
        return c;
    endfunction

    function automatic logic [10:0] ham_dec(input logic [14:0] cw);
        logic [14:0] c;
        logic [10:0] d;
        int          s;
        int          j;
        c = cw;
        s = 0;
        for (int p = 1; p <= 15; p++) if (c[p-1]) s = s ^ p;
        if (s != 0) c[s-1] = ~c[s-1];
        d = '0;
        j = 0;
        for (int p = 1; p <= 15; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[j] = c[p-1];
                j++;
            end
        end
        return d;
    endfunction

    logic irq_ctrl;
    logic corr_ctrl;

    always_comb begin
        bus.ecc_codeword = ham_enc(bus.ecc_packet);
        bus.ecc_data     = ham_dec(bus.ecc_frame);
        bus.ecc_irq      = irq_ctrl;
        bus.ecc_correct  = corr_ctrl;
    end

    typedef struct {
        bit          is_tx;
        logic [14:0] frame;
        logic [10:0] data;
        bit          ok;
        bit          tmo;
        int          at;
    } exp_t;

    exp_t        sb[$];
    logic [14:0] exp_tx_frame = '0;
    logic [10:0] exp_rx_data  = '0;

    task automatic chk(input string name, input longint act, input longint req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input bit is_tx, input logic [14:0] f, input logic [10:0] d,
                        input bit ok, input bit tmo, input int at);
        exp_t e;
        if (!tmo) begin
            if (is_tx) exp_tx_frame = f;
            else       exp_rx_data  = d;
        end
        e.is_tx = is_tx;
        e.frame = exp_tx_frame;
        e.data  = exp_rx_data;
        e.ok    = ok;
        e.tmo   = tmo;
        e.at    = at;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input bit is_tx);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (is_tx ? bus.tx_ack : bus.rx_ack) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL ack_wait: no %s ack within 40 cycles, required one", is_tx ? "tx" : "rx");
    endtask

    task automatic drop_reqs();
        bus.tx_req = 1'b0;
        bus.rx_req = 1'b0;
    endtask

    // Plain job with irq already high: ack lands 3 cycles after the request cycle.
    task automatic run_job(input bit is_tx, input logic [14:0] opnd,
                           input logic [14:0] ev, input bit ok);
        int c;
        @(negedge clk);
        c = cyc;
        if (is_tx) begin
            bus.tx_packet = opnd[10:0];
            bus.tx_req    = 1'b1;
        end else begin
            bus.rx_frame = opnd;
            bus.rx_req   = 1'b1;
        end
        push(is_tx, ev, ev[10:0], ok, 1'b0, c + 3);
        wait_ack(is_tx);
        drop_reqs();
    endtask

    task automatic chk_reset_values();
        chk("rst_tx_ack",   bus.tx_ack,        0);
        chk("rst_rx_ack",   bus.rx_ack,        0);
        chk("rst_timeout",  bus.timeout,       0);
        chk("rst_rx_ok",    bus.rx_ok,         0);
        chk("rst_tx_frame", bus.tx_frame,      0);
        chk("rst_rx_data",  bus.rx_data,       0);
        chk("rst_ecc_pkt",  bus.ecc_packet,    0);
        chk("rst_ecc_frm",  bus.ecc_frame,     0);
        chk("rst_ecc_op",   bus.ecc_operation, 0);
        chk("rst_err_cnt",  bus.err_count,     0);
    endtask

    // Monitor: every ack is matched against the oldest scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && (bus.tx_ack || bus.rx_ack)) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_ack: tx_ack=%0b rx_ack=%0b, required none",
                         bus.tx_ack, bus.rx_ack);
            end else begin
                e = sb.pop_front();
                chk("ack_side",  bus.tx_ack,  e.is_tx);
                chk("ack_other", bus.rx_ack,  !e.is_tx);
                chk("ack_cycle", cyc,         e.at);
                chk("timeout",   bus.timeout, e.tmo);
                if (e.is_tx) begin
                    chk("tx_frame", bus.tx_frame, e.frame);
                end else begin
                    chk("rx_data", bus.rx_data, e.data);
                    chk("rx_ok",   bus.rx_ok,   e.ok);
                end
            end
        end else if (!reset && bus.timeout) begin
            n_tests++;
            n_fail++;
            $display("FAIL stray_timeout: timeout=1 without ack, required 0");
        end
    end

    initial begin
        #200000;
        $display("FAIL global_watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        reset         = 1'b1;
        irq_ctrl      = 1'b1;
        corr_ctrl     = 1'b1;
        bus.tx_req    = 1'b0;
        bus.rx_req    = 1'b0;
        bus.tx_packet = '0;
        bus.rx_frame  = '0;
        repeat (3) @(negedge clk);
        chk_reset_values();

        // Contention straight out of reset: TX first, RX four cycles later.
        reset         = 1'b0;
        c             = cyc;
        bus.tx_packet = 11'h001;
        bus.rx_frame  = 15'h7FFE;
        bus.tx_req    = 1'b1;
        bus.rx_req    = 1'b1;
        push(1'b1, 15'h0007, 11'h000, 1'b1, 1'b0, c + 3);
        push(1'b0, 15'h0000, 11'h7FF, 1'b1, 1'b0, c + 7);
        wait_ack(1'b1);
        bus.tx_req = 1'b0;
        wait_ack(1'b0);
        bus.rx_req = 1'b0;

        // Single encode and a one-bit-error decode of the same packet.
        run_job(1'b1, 15'h0042, 15'h049A, 1'b1);
        chk("enc_ecc_op", bus.ecc_operation, 0);
        run_job(1'b0, 15'h04DA, 15'h0042, 1'b1);
        chk("dec_ecc_op", bus.ecc_operation, 1);
        @(negedge clk);
        chk("err_after_ok_dec", bus.err_count, 0);

        // irq rises on WAIT cycle 3: ack 5 cycles after the request cycle.
        irq_ctrl = 1'b0;
        @(negedge clk);
        c             = cyc;
        bus.tx_packet = 11'h7FF;
        bus.tx_req    = 1'b1;
        push(1'b1, 15'h7FFF, 11'h000, 1'b1, 1'b0, c + 5);
        repeat (4) @(negedge clk);
        irq_ctrl = 1'b1;
        wait_ack(1'b1);
        drop_reqs();

        // Stale irq in IDLE/ISSUE only, then silence: RX job times out.
        @(negedge clk);
        c            = cyc;
        bus.rx_frame = 15'h0000;
        bus.rx_req   = 1'b1;
        irq_ctrl     = 1'b1;
        push(1'b0, 15'h0000, 11'h000, 1'b0, 1'b1, c + 2 + TMO);
        repeat (2) @(negedge clk);
        irq_ctrl = 1'b0;
        wait_ack(1'b0);
        drop_reqs();
        @(negedge clk);
        chk("err_after_tmo", bus.err_count, ERR_AFTER_TMO);
        irq_ctrl = 1'b1;

        // Reset on the second WAIT cycle: no ack, everything back to reset values.
        irq_ctrl = 1'b0;
        @(negedge clk);
        bus.tx_packet = 11'h123;
        bus.tx_req    = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        drop_reqs();
        @(negedge clk);
        chk_reset_values();
        reset        = 1'b0;
        irq_ctrl     = 1'b1;
        exp_tx_frame = '0;
        exp_rx_data  = '0;
        run_job(1'b1, 15'h0042, 15'h049A, 1'b1);

        // Failing decodes drive err_count to saturation.
        corr_ctrl = 1'b0;
        for (int i = 0; i < 260; i++) run_job(1'b0, 15'h0007, 15'h0001, 1'b0);
        corr_ctrl = 1'b1;
        repeat (2) @(negedge clk);
        chk("err_saturated", bus.err_count, ERR_SAT);
        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
